// File: rtl/control_unit_pkg.sv
// Shared codes for the control sequencer: opcodes, ALU operations, instruction classes,
// FSM states and the packed strobe bundle that the sequencer registers every cycle.
// Pure declarations; no timing or flow-control behaviour of its own.
package control_unit_pkg;

    // Opcodes live in ir[31:27]
    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_ADDI = 5'd12;
    localparam logic [4:0] OP_ANDI = 5'd13;
    localparam logic [4:0] OP_ORI  = 5'd14;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_BR   = 5'd18;
    localparam logic [4:0] OP_JR   = 5'd19;
    localparam logic [4:0] OP_MFHI = 5'd22;
    localparam logic [4:0] OP_MFLO = 5'd23;
    localparam logic [4:0] OP_NOP  = 5'd26;
    localparam logic [4:0] OP_HALT = 5'd27;

    typedef enum logic [4:0] {
        ALU_NOP = 5'd0,
        ALU_ADD = 5'd1,
        ALU_SUB = 5'd2,
        ALU_AND = 5'd3,
        ALU_OR  = 5'd4,
        ALU_MUL = 5'd5,
        ALU_DIV = 5'd6
    } alu_op_t;

    // Execute-phase class; each class owns one fixed T3..Tn strobe sequence
    typedef enum logic [3:0] {
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_LDI,
        CLS_LD,
        CLS_ST,
        CLS_MULDIV,
        CLS_BR,
        CLS_JR,
        CLS_MFHI,
        CLS_MFLO,
        CLS_NOP,
        CLS_HALT,
        CLS_ILL
    } cls_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic    gra;
        logic    grb;
        logic    grc;
        logic    rin;
        logic    rout;
        logic    ba_out;
        logic    pc_out;
        logic    pc_in;
        logic    inc_pc;
        logic    mar_in;
        logic    mdr_in;
        logic    mdr_read;
        logic    mdr_out;
        logic    ir_in;
        logic    y_in;
        logic    z_in;
        logic    zlo_out;
        logic    zhi_out;
        logic    c_out;
        logic    hi_in;
        logic    hi_out;
        logic    lo_in;
        logic    lo_out;
        logic    con_ff_in;
        logic    wr_en;
        logic    illegal;
        alu_op_t alu_op;
    } strobes_t;

    localparam strobes_t STROBES_OFF = '0;

    // Final execute step of each class; the sequencer returns to T0 after it
    function automatic logic [2:0] last_step(cls_t cls);
        case (cls)
            CLS_ALU_R, CLS_ALU_I, CLS_LDI: return 3'd5;
            CLS_MULDIV, CLS_BR:            return 3'd6;
            CLS_LD, CLS_ST:                return 3'd7;
            default:                       return 3'd3;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bundle between the control sequencer (master) and the datapath (slave): IR/CON/run in,
// every datapath strobe out. mem_ready exists only when CU_MEM_WAIT_EN is defined.
// No flow control on the bus itself; strobes are level signals valid for one whole cycle.
interface control_unit_if;
    logic        run;
    logic [31:0] ir;
    logic        con;
`ifdef CU_MEM_WAIT_EN
    logic        mem_ready;
`endif
    logic Gra, Grb, Grc, Rin, Rout, BaOut;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRread, MDRout, IRin;
    logic Yin, Zin, ZLOout, ZHIout, Cout, HIin, HIout, Loin, Loout;
    logic CON_ff_in, WRen;
    logic [4:0] ALU_opcode;
    logic halted;
    logic illegal;

    modport master (
`ifdef CU_MEM_WAIT_EN
        input  mem_ready,
`endif
        input  run, ir, con,
        output Gra, Grb, Grc, Rin, Rout, BaOut,
        output PCout, PCin, IncPC, MARin, MDRin, MDRread, MDRout, IRin,
        output Yin, Zin, ZLOout, ZHIout, Cout, HIin, HIout, Loin, Loout,
        output CON_ff_in, WRen, ALU_opcode, halted, illegal
    );

    modport slave (
`ifdef CU_MEM_WAIT_EN
        output mem_ready,
`endif
        output run, ir, con,
        input  Gra, Grb, Grc, Rin, Rout, BaOut,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRread, MDRout, IRin,
        input  Yin, Zin, ZLOout, ZHIout, Cout, HIin, HIout, Loin, Loout,
        input  CON_ff_in, WRen, ALU_opcode, halted, illegal
    );
endinterface

// File: rtl/control_unit_instr_class_decode.sv
// Opcode -> execute class and ALU operation; unknown opcodes map to CLS_ILL.
// Purely combinational, zero latency.
// No backpressure; the sequencer samples the result only in T2.
// Ports: op (ir[31:27]) in; cls, alu_op out.
module instr_class_decode
    import control_unit_pkg::*;
(
    input  logic [4:0] op,
    output cls_t       cls,
    output alu_op_t    alu_op
);

    always_comb begin
        cls    = CLS_ILL;
        alu_op = ALU_NOP;
        case (op)
            OP_LD:   begin cls = CLS_LD;     alu_op = ALU_ADD; end
            OP_LDI:  begin cls = CLS_LDI;    alu_op = ALU_ADD; end
            OP_ST:   begin cls = CLS_ST;     alu_op = ALU_ADD; end
            OP_ADD:  begin cls = CLS_ALU_R;  alu_op = ALU_ADD; end
            OP_SUB:  begin cls = CLS_ALU_R;  alu_op = ALU_SUB; end
            OP_AND:  begin cls = CLS_ALU_R;  alu_op = ALU_AND; end
            OP_OR:   begin cls = CLS_ALU_R;  alu_op = ALU_OR;  end
            OP_ADDI: begin cls = CLS_ALU_I;  alu_op = ALU_ADD; end
            OP_ANDI: begin cls = CLS_ALU_I;  alu_op = ALU_AND; end
            OP_ORI:  begin cls = CLS_ALU_I;  alu_op = ALU_OR;  end
            OP_MUL:  begin cls = CLS_MULDIV; alu_op = ALU_MUL; end
            OP_DIV:  begin cls = CLS_MULDIV; alu_op = ALU_DIV; end
            OP_BR:   begin cls = CLS_BR;     alu_op = ALU_ADD; end
            OP_JR:   cls = CLS_JR;
            OP_MFHI: cls = CLS_MFHI;
            OP_MFLO: cls = CLS_MFLO;
            OP_NOP:  cls = CLS_NOP;
            OP_HALT: cls = CLS_HALT;
            default: cls = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control sequencer: fetch T0-T2, execute T3-T7, strobes registered (Moore).
// Strobes for a step appear the cycle the sequencer is in that step; clr clears them at once.
// With CU_MEM_WAIT_EN, T1 / ld-T6 / st-T7 hold until mem_ready=1; otherwise every step is 1 cycle.
// Ports: clk, clr (async active-high); bus = control_unit_if.master (run, ir, con, [mem_ready] in;
//        datapath strobes, ALU_opcode, halted, illegal out). Parameter AUTO_RUN: leave IDLE without run.
module control_unit
    import control_unit_pkg::*;
#(
    parameter bit AUTO_RUN = 1'b0
) (
    input  logic           clk,
    input  logic           clr,
    control_unit_if.master bus
);

    state_t   state_q, state_d;
    logic [2:0] step_q, step_d;
    cls_t     cls_q, cls_d;
    alu_op_t  alu_q, alu_d;
    logic     halted_q, halted_d;
    strobes_t strobes_q, strobes_d;

    cls_t     dec_cls;
    alu_op_t  dec_alu;
    logic     mem_ok;
    logic     mem_hold;
    logic     ir_unused;

    // Only the opcode field steers sequencing; operand fields go straight to the datapath
    assign ir_unused = ^bus.ir[26:0];

`ifdef CU_MEM_WAIT_EN
    assign mem_ok = bus.mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    instr_class_decode u_decode (
        .op     (bus.ir[31:27]),
        .cls    (dec_cls),
        .alu_op (dec_alu)
    );

    // Memory-access execute steps that stretch while memory is busy
    assign mem_hold = !mem_ok &&
                      (((cls_q == CLS_LD) && (step_q == 3'd6)) ||
                       ((cls_q == CLS_ST) && (step_q == 3'd7)));

    // Strobe set belonging to a given (state, step, class). Evaluated on the next-state values so
    // the flops hold exactly the strobes of the state register they are loaded alongside.
    function automatic strobes_t strobes_for(state_t st, logic [2:0] step, cls_t cls,
                                             alu_op_t alu, logic con);
        strobes_t s;
        s = STROBES_OFF;
        if (st == ST_RUN) begin
            case (step)
                3'd0: begin s.pc_out = 1'b1; s.mar_in = 1'b1; s.inc_pc = 1'b1; end
                3'd1: begin s.mdr_read = 1'b1; s.mdr_in = 1'b1; end
                3'd2: begin s.mdr_out = 1'b1; s.ir_in = 1'b1; end
                default: begin
                    case (cls)
                        CLS_ALU_R, CLS_ALU_I: begin
                            case (step)
                                3'd3: begin s.grb = 1'b1; s.rout = 1'b1; s.y_in = 1'b1; end
                                3'd4: begin
                                    s.z_in   = 1'b1;
                                    s.alu_op = alu;
                                    if (cls == CLS_ALU_R) begin
                                        s.grc  = 1'b1;
                                        s.rout = 1'b1;
                                    end else begin
                                        s.c_out = 1'b1;
                                    end
                                end
                                3'd5: begin s.zlo_out = 1'b1; s.gra = 1'b1; s.rin = 1'b1; end
                                default: ;
                            endcase
                        end
                        CLS_LDI, CLS_LD, CLS_ST: begin
                            case (step)
                                3'd3: begin s.grb = 1'b1; s.ba_out = 1'b1; s.y_in = 1'b1; end
                                3'd4: begin s.c_out = 1'b1; s.z_in = 1'b1; s.alu_op = ALU_ADD; end
                                3'd5: begin
                                    s.zlo_out = 1'b1;
                                    if (cls == CLS_LDI) begin
                                        s.gra = 1'b1;
                                        s.rin = 1'b1;
                                    end else begin
                                        s.mar_in = 1'b1;
                                    end
                                end
                                3'd6: begin
                                    s.mdr_in = 1'b1;
                                    if (cls == CLS_LD) begin
                                        s.mdr_read = 1'b1;
                                    end else if (cls == CLS_ST) begin
                                        s.gra  = 1'b1;
                                        s.rout = 1'b1;
                                    end
                                end
                                3'd7: begin
                                    if (cls == CLS_LD) begin
                                        s.mdr_out = 1'b1;
                                        s.gra     = 1'b1;
                                        s.rin     = 1'b1;
                                    end else if (cls == CLS_ST) begin
                                        s.wr_en = 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                        CLS_MULDIV: begin
                            case (step)
                                3'd3: begin s.gra = 1'b1; s.rout = 1'b1; s.y_in = 1'b1; end
                                3'd4: begin s.grb = 1'b1; s.rout = 1'b1; s.z_in = 1'b1; s.alu_op = alu; end
                                3'd5: begin s.zlo_out = 1'b1; s.lo_in = 1'b1; end
                                3'd6: begin s.zhi_out = 1'b1; s.hi_in = 1'b1; end
                                default: ;
                            endcase
                        end
                        CLS_BR: begin
                            case (step)
                                3'd3: begin s.gra = 1'b1; s.rout = 1'b1; s.con_ff_in = 1'b1; end
                                3'd4: begin s.pc_out = 1'b1; s.y_in = 1'b1; end
                                3'd5: begin s.c_out = 1'b1; s.z_in = 1'b1; s.alu_op = ALU_ADD; end
                                // CON was latched in T3, so it is stable when T6 is entered
                                3'd6: begin s.zlo_out = con; s.pc_in = con; end
                                default: ;
                            endcase
                        end
                        CLS_JR:   if (step == 3'd3) begin s.gra = 1'b1; s.rout = 1'b1; s.pc_in = 1'b1; end
                        CLS_MFHI: if (step == 3'd3) begin s.hi_out = 1'b1; s.gra = 1'b1; s.rin = 1'b1; end
                        CLS_MFLO: if (step == 3'd3) begin s.lo_out = 1'b1; s.gra = 1'b1; s.rin = 1'b1; end
                        CLS_ILL:  if (step == 3'd3) s.illegal = 1'b1;
                        default: ;
                    endcase
                end
            endcase
        end
        return s;
    endfunction

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        cls_d    = cls_q;
        alu_d    = alu_q;
        halted_d = halted_q;
        case (state_q)
            ST_IDLE: begin
                if (AUTO_RUN || bus.run) begin
                    state_d = ST_RUN;
                    step_d  = 3'd0;
                end
            end
            ST_RUN: begin
                if (step_q == 3'd0) begin
                    step_d = 3'd1;
                end else if (step_q == 3'd1) begin
                    if (mem_ok) step_d = 3'd2;
                end else if (step_q == 3'd2) begin
                    // Class is captured here so later ir changes cannot disturb execute strobes
                    step_d = 3'd3;
                    cls_d  = dec_cls;
                    alu_d  = dec_alu;
                end else if (cls_q == CLS_HALT) begin
                    state_d  = ST_HALT;
                    step_d   = 3'd0;
                    halted_d = 1'b1;
                end else if (mem_hold) begin
                    step_d = step_q;
                end else if (step_q == last_step(cls_q)) begin
                    step_d = 3'd0;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
        strobes_d = strobes_for(state_d, step_d, cls_d, alu_d, bus.con);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            step_q    <= 3'd0;
            cls_q     <= CLS_NOP;
            alu_q     <= ALU_NOP;
            halted_q  <= 1'b0;
            strobes_q <= STROBES_OFF;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            cls_q     <= cls_d;
            alu_q     <= alu_d;
            halted_q  <= halted_d;
            strobes_q <= strobes_d;
        end
    end

    assign bus.Gra        = strobes_q.gra;
    assign bus.Grb        = strobes_q.grb;
    assign bus.Grc        = strobes_q.grc;
    assign bus.Rin        = strobes_q.rin;
    assign bus.Rout       = strobes_q.rout;
    assign bus.BaOut      = strobes_q.ba_out;
    assign bus.PCout      = strobes_q.pc_out;
    assign bus.PCin       = strobes_q.pc_in;
    assign bus.IncPC      = strobes_q.inc_pc;
    assign bus.MARin      = strobes_q.mar_in;
    assign bus.MDRin      = strobes_q.mdr_in;
    assign bus.MDRread    = strobes_q.mdr_read;
    assign bus.MDRout     = strobes_q.mdr_out;
    assign bus.IRin       = strobes_q.ir_in;
    assign bus.Yin        = strobes_q.y_in;
    assign bus.Zin        = strobes_q.z_in;
    assign bus.ZLOout     = strobes_q.zlo_out;
    assign bus.ZHIout     = strobes_q.zhi_out;
    assign bus.Cout       = strobes_q.c_out;
    assign bus.HIin       = strobes_q.hi_in;
    assign bus.HIout      = strobes_q.hi_out;
    assign bus.Loin       = strobes_q.lo_in;
    assign bus.Loout      = strobes_q.lo_out;
    assign bus.CON_ff_in  = strobes_q.con_ff_in;
    assign bus.WRen       = strobes_q.wr_en;
    assign bus.ALU_opcode = strobes_q.alu_op;
    assign bus.illegal    = strobes_q.illegal;
    assign bus.halted     = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction expected strobe vectors are queued when the
// instruction is issued and popped/compared one per cycle while the DUT sequences it.
module tb_control_unit;
    import control_unit_pkg::*;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    control_unit_if bus ();

    control_unit #(.AUTO_RUN(1'b0)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    localparam logic [31:0] GRA = 32'd1 << 0,  GRB = 32'd1 << 1,  GRC = 32'd1 << 2,
                            RIN = 32'd1 << 3,  ROUT = 32'd1 << 4, BAOUT = 32'd1 << 5,
                            PCOUT = 32'd1 << 6, PCIN = 32'd1 << 7, INCPC = 32'd1 << 8,
                            MARIN = 32'd1 << 9, MDRIN = 32'd1 << 10, MDRREAD = 32'd1 << 11,
                            MDROUT = 32'd1 << 12, IRIN = 32'd1 << 13, YIN = 32'd1 << 14,
                            ZIN = 32'd1 << 15, ZLO = 32'd1 << 16, ZHI = 32'd1 << 17,
                            COUT = 32'd1 << 18, HIIN = 32'd1 << 19, HIOUT = 32'd1 << 20,
                            LOIN = 32'd1 << 21, LOOUT = 32'd1 << 22, CONIN = 32'd1 << 23,
                            WREN = 32'd1 << 24, HALTED = 32'd1 << 25, ILL = 32'd1 << 26;
    localparam logic [31:0] FT0 = PCOUT | MARIN | INCPC;
    localparam logic [31:0] FT1 = MDRREAD | MDRIN;
    localparam logic [31:0] FT2 = MDROUT | IRIN;

    localparam logic [4:0] MISC_OPS [13] = '{OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI,
                                             OP_LDI, OP_MUL, OP_DIV, OP_JR, OP_MFHI, OP_MFLO, OP_NOP};

    typedef struct packed {
        logic [31:0] exp;
        logic        rdy;
        logic [31:0] ir;
    } ent_t;

    ent_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] observe();
        return {bus.ALU_opcode, bus.illegal, bus.halted, bus.WRen, bus.CON_ff_in, bus.Loout,
                bus.Loin, bus.HIout, bus.HIin, bus.Cout, bus.ZHIout, bus.ZLOout, bus.Zin,
                bus.Yin, bus.IRin, bus.MDRout, bus.MDRread, bus.MDRin, bus.MARin, bus.IncPC,
                bus.PCin, bus.PCout, bus.BaOut, bus.Rout, bus.Rin, bus.Grc, bus.Grb, bus.Gra};
    endfunction

    function automatic logic [31:0] alu_f(alu_op_t a);
        return {a, 27'd0};
    endfunction

    function automatic alu_op_t tb_alu(logic [4:0] op);
        case (op)
            OP_ADD, OP_ADDI: return ALU_ADD;
            OP_SUB:          return ALU_SUB;
            OP_AND, OP_ANDI: return ALU_AND;
            OP_OR, OP_ORI:   return ALU_OR;
            OP_MUL:          return ALU_MUL;
            OP_DIV:          return ALU_DIV;
            default:         return ALU_NOP;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] e, input logic r, input logic [31:0] irv);
        ent_t en;
        en.exp = e;
        en.rdy = r;
        en.ir  = irv;
        sb_q.push_back(en);
    endtask

    // Execute-phase entry; ir is scrambled to show it is ignored after T2
    task automatic x(input logic [31:0] e, input logic r = 1'b1);
        push(e, r, $urandom());
    endtask

    // Queue the full expected strobe sequence of one instruction starting at T0.
    // t1w / mw: cycles memory stays not-ready in T1 and in ld-T6 / st-T7.
    task automatic push_instr(input logic [31:0] irv, input logic conv, input int t1w, input int mw);
        logic [4:0] op;
        alu_op_t    a;
        op = irv[31:27];
        a  = tb_alu(op);
        push(FT0, 1'b1, irv);
        for (int k = 0; k < t1w; k++) push(FT1, 1'b0, irv);
        push(FT1, 1'b1, irv);
        push(FT2, 1'b1, irv);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                x(GRB | ROUT | YIN); x(GRC | ROUT | ZIN | alu_f(a)); x(ZLO | GRA | RIN);
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                x(GRB | ROUT | YIN); x(COUT | ZIN | alu_f(a)); x(ZLO | GRA | RIN);
            end
            OP_LDI: begin
                x(GRB | BAOUT | YIN); x(COUT | ZIN | alu_f(ALU_ADD)); x(ZLO | GRA | RIN);
            end
            OP_LD: begin
                x(GRB | BAOUT | YIN); x(COUT | ZIN | alu_f(ALU_ADD)); x(ZLO | MARIN);
                for (int k = 0; k < mw; k++) x(MDRREAD | MDRIN, 1'b0);
                x(MDRREAD | MDRIN); x(MDROUT | GRA | RIN);
            end
            OP_ST: begin
                x(GRB | BAOUT | YIN); x(COUT | ZIN | alu_f(ALU_ADD)); x(ZLO | MARIN);
                x(GRA | ROUT | MDRIN);
                for (int k = 0; k < mw; k++) x(WREN, 1'b0);
                x(WREN);
            end
            OP_MUL, OP_DIV: begin
                x(GRA | ROUT | YIN); x(GRB | ROUT | ZIN | alu_f(a)); x(ZLO | LOIN); x(ZHI | HIIN);
            end
            OP_BR: begin
                x(GRA | ROUT | CONIN); x(PCOUT | YIN); x(COUT | ZIN | alu_f(ALU_ADD));
                x(conv ? (ZLO | PCIN) : 32'd0);
            end
            OP_JR:   x(GRA | ROUT | PCIN);
            OP_MFHI: x(HIOUT | GRA | RIN);
            OP_MFLO: x(LOOUT | GRA | RIN);
            OP_NOP, OP_HALT: x(32'd0);
            default: x(ILL);
        endcase
    endtask

    // Compare n queued entries (all when n < 0), one per cycle
    task automatic drain(input string name, input int n);
        ent_t        en;
        logic [31:0] obs;
        int          i;
        i = 0;
        while (sb_q.size() > 0 && (n < 0 || i < n)) begin
            en = sb_q.pop_front();
`ifdef CU_MEM_WAIT_EN
            bus.mem_ready = en.rdy;
`endif
            bus.ir = en.ir;
            obs = observe();
            total++;
            if (obs !== en.exp) begin
                bad++;
                $display("FAIL %s[%0d]: got %h want %h", name, i, obs, en.exp);
            end
            tick();
            i++;
        end
`ifdef CU_MEM_WAIT_EN
        bus.mem_ready = 1'b1;
`endif
    endtask

    task automatic check_now(input string name, input logic [31:0] want);
        logic [31:0] obs;
        obs = observe();
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, obs, want);
        end
    endtask

    task automatic restart();
        bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        check_now("restart_t0", FT0);
    endtask

    task automatic test_reset();
        clr     = 1'b1;
        bus.run = 1'b0;
        bus.con = 1'b0;
        bus.ir  = 32'h0;
`ifdef CU_MEM_WAIT_EN
        bus.mem_ready = 1'b1;
`endif
        tick();
        tick();
        check_now("reset_outputs", 32'd0);
        clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_now("idle_wait_run", 32'd0);
        end
        restart();
    endtask

    task automatic test_alu();
        push_instr(32'h19890000, 1'b0, 0, 0);
        drain("add_r3_r1_r2", -1);
        for (int i = 0; i < 13; i++) begin
            push_instr({MISC_OPS[i], 4'(i), 4'd5, 4'd9, 15'h0}, 1'b0, 0, 0);
            drain($sformatf("op%0d", MISC_OPS[i]), -1);
        end
    endtask

    task automatic test_load_store();
        push_instr({OP_LD, 4'd2, 4'd1, 19'h14}, 1'b0, 0, 0);
        drain("ld_r2_0x14_r1", -1);
        push_instr({OP_ST, 4'd4, 4'd1, 19'h20}, 1'b0, 0, 0);
        drain("st_r4", -1);
    endtask

    task automatic test_branch();
        bus.con = 1'b0;
        push_instr({OP_BR, 4'd3, 4'd0, 19'h8}, 1'b0, 0, 0);
        drain("br_not_taken", -1);
        bus.con = 1'b1;
        push_instr({OP_BR, 4'd3, 4'd0, 19'h8}, 1'b1, 0, 0);
        drain("br_taken", -1);
        bus.con = 1'b0;
    endtask

    task automatic test_illegal();
        push_instr({5'd31, 27'h0}, 1'b0, 0, 0);
        drain("illegal_op31", -1);
        push_instr({5'd7, 27'h123}, 1'b0, 0, 0);
        drain("illegal_op7", -1);
    endtask

`ifdef CU_MEM_WAIT_EN
    task automatic test_mem_wait();
        push_instr({OP_ADD, 4'd1, 4'd2, 4'd3, 15'h0}, 1'b0, 3, 0);
        drain("t1_wait3", -1);
        push_instr({OP_LD, 4'd2, 4'd1, 19'h14}, 1'b0, 1, 2);
        drain("ld_t6_wait2", -1);
        push_instr({OP_ST, 4'd2, 4'd1, 19'h14}, 1'b0, 0, 1);
        drain("st_t7_wait1", -1);
    endtask
`endif

    task automatic test_clr_mid();
        ent_t en;
        push_instr({OP_LD, 4'd2, 4'd1, 19'h14}, 1'b0, 0, 0);
        drain("ld_before_clr", 5);
        en = sb_q.pop_front();
        check_now("ld_t5", en.exp);
        sb_q.delete();
        clr = 1'b1;
        #1;
        check_now("clr_mid_ld_same_cycle", 32'd0);
        tick();
        clr = 1'b0;
        tick();
        check_now("idle_after_clr", 32'd0);
        restart();
    endtask

    task automatic test_halt();
        push_instr({OP_HALT, 27'h0}, 1'b0, 0, 0);
        drain("halt_fetch", -1);
        bus.run = 1'b1;
        for (int k = 0; k < 20; k++) push(HALTED, 1'b1, $urandom());
        drain("halted_hold", -1);
        clr = 1'b1;
        #1;
        check_now("halt_clr", 32'd0);
        tick();
        clr     = 1'b0;
        bus.run = 1'b0;
        tick();
        check_now("idle_after_halt", 32'd0);
        restart();
        push_instr({OP_ADD, 4'd5, 4'd6, 4'd7, 15'h0}, 1'b0, 0, 0);
        drain("add_after_halt", -1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_illegal();
`ifdef CU_MEM_WAIT_EN
        test_mem_wait();
`endif
        test_clr_mid();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
